// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, oversampling rate, defaults, parity helper.
package uart_pkg;

  // Ticks of the baud enable per bit period.
  localparam int unsigned OS_TICK = 16;

  // Frame defaults shared by transmitter and receiver.
  localparam int unsigned N_BITS_DEF  = 8;
  localparam int unsigned SB_TICK_DEF = 16;

  // State encoding is common to uart_tx and uart_rx; codes 5..7 are illegal.
  typedef logic [2:0] state_t;
  localparam state_t StIdle   = 3'd0;
  localparam state_t StStart  = 3'd1;
  localparam state_t StData   = 3'd2;
  localparam state_t StParity = 3'd3;
  localparam state_t StStop   = 3'd4;

  // Even parity over up to 32 data bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start, N_BITS data LSB first, even parity, SB_TICK ticks of stop.
// A one-entry holding register lets a second byte queue up during a frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned N_BITS  = N_BITS_DEF,  // 1..32
  parameter int unsigned SB_TICK = SB_TICK_DEF  // 16/24/32 = 1/1.5/2 stop bits
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  input  logic              tx_start,
  input  logic [N_BITS-1:0] din,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done_tick,
  output logic              tx
);

  localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (N_BITS > 2) ? $clog2(N_BITS) : 1;

  localparam logic [SW-1:0] BitLast  = SW'(OS_TICK - 1);
  localparam logic [SW-1:0] StopLast = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast    = NW'(N_BITS - 1);

  state_t              state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [NW-1:0]       n_q, n_d;
  logic [N_BITS-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [N_BITS-1:0]   hold_q, hold_d;
  logic                hold_par_q, hold_par_d;
  logic                hold_valid_q, hold_valid_d;
  logic                tx_q, tx_d;

  logic                accept;
  logic                stop_end;
  logic                load_direct;
  logic                transfer;
  logic                illegal;
  logic                din_par;

  assign accept  = tx_start & ~hold_valid_q;
  assign din_par = even_parity(32'(din));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      s_q          <= '0;
      n_q          <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      hold_q       <= '0;
      hold_par_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      hold_q       <= hold_d;
      hold_par_q   <= hold_par_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
    end
  end

  // Next-state: bit sequencing on s_tick, plus direct/held loading of new bytes.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    shift_d      = shift_q;
    par_d        = par_q;
    hold_d       = hold_q;
    hold_par_d   = hold_par_q;
    hold_valid_d = hold_valid_q;
    stop_end     = 1'b0;
    load_direct  = 1'b0;
    transfer     = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      StIdle: begin
        // Held byte in idle is unreachable in normal flow but drains safely if it occurs.
        if (hold_valid_q) transfer = 1'b1;
        else if (accept)  load_direct = 1'b1;
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == BitLast) begin
            s_d     = '0;
            n_d     = '0;
            state_d = StData;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == BitLast) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            n_d     = n_q + 1'b1;
            if (n_q == NLast) state_d = StParity;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (s_tick) begin
          if (s_q == BitLast) begin
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == StopLast) begin
            stop_end = 1'b1;
            s_d      = '0;
            if (hold_valid_q) transfer = 1'b1;
            else if (accept)  load_direct = 1'b1;
            else              state_d = StIdle;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        illegal = 1'b1;
        state_d = StIdle;
        s_d     = '0;
        n_d     = '0;
      end
    endcase

    if (transfer) begin
      shift_d      = hold_q;
      par_d        = hold_par_q;
      hold_valid_d = 1'b0;
      state_d      = StStart;
      s_d          = '0;
    end else if (load_direct) begin
      shift_d = din;
      par_d   = din_par;
      state_d = StStart;
      s_d     = '0;
    end else if (accept && !illegal) begin
      // Busy mid-frame: park the byte until the current stop time ends.
      hold_d       = din;
      hold_par_d   = din_par;
      hold_valid_d = 1'b1;
    end

    if (illegal) hold_valid_d = 1'b0;
  end

  // Outputs: line level follows the next state so tx is registered with no extra latency.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    tx_done_tick = stop_end & ~reset;
  end

  assign tx       = tx_q;
  assign tx_busy  = (state_q != StIdle);
  assign tx_ready = ~hold_valid_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default instance (1 stop bit) and a 2-stop-bit instance.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset   = 1'b1;
  logic       s_tick  = 1'b0;
  logic       tick_en = 1'b1;
  int         div     = 0;
  int         tick_cnt = 0;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] din_a = 8'h00, din_b = 8'h00;
  logic       ready_a, busy_a, done_a, tx_a;
  logic       ready_b, busy_b, done_b, tx_b;

  logic       sel = 1'b0;
  logic       obs_tx, obs_busy, obs_ready, obs_done;
  assign obs_tx    = sel ? tx_b    : tx_a;
  assign obs_busy  = sel ? busy_b  : busy_a;
  assign obs_ready = sel ? ready_b : ready_a;
  assign obs_done  = sel ? done_b  : done_a;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt_a = 0;

  uart_tx #(.N_BITS(8), .SB_TICK(16)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (start_a),
    .din          (din_a),
    .tx_ready     (ready_a),
    .tx_busy      (busy_a),
    .tx_done_tick (done_a),
    .tx           (tx_a)
  );

  uart_tx #(.N_BITS(8), .SB_TICK(32)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (start_b),
    .din          (din_b),
    .tx_ready     (ready_b),
    .tx_busy      (busy_b),
    .tx_done_tick (done_b),
    .tx           (tx_b)
  );

  // Baud enable: one pulse every 4 clocks while enabled.
  always @(posedge clk) begin
    s_tick <= tick_en && (div == 3);
    div    <= (div == 3) ? 0 : div + 1;
  end

  // Tick and done-pulse counters.
  always @(posedge clk) begin
    if (s_tick) tick_cnt <= tick_cnt + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input int target);
    int guard = 0;
    while (tick_cnt < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (tick_cnt < target) chk("tick_wait_timeout", tick_cnt, target);
  endtask

  // Request a byte on the selected instance while it is idle; returns the tick count at load.
  task automatic start_frame(input logic s, input logic [7:0] d, output int t0);
    sel = s;
    if (s) begin din_b = d; start_b = 1'b1; end
    else   begin din_a = d; start_a = 1'b1; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    t0 = tick_cnt;
    chk("start_tx_low", obs_tx, 1'b0);
    chk("busy_after_load", obs_busy, 1'b1);
    @(negedge clk);
  endtask

  // Sample each bit mid-period, then check the done pulse lands at the frame length.
  task automatic check_bits(input logic [7:0] d, input int sb, input int t0,
                            input int stall_bit, input bit expect_idle);
    logic [10:0] exp_bits;
    logic        held;
    int          changes;
    bit          found;
    exp_bits = {1'b1, ^d, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      wait_tick(t0 + 16 * b + 8);
      chk($sformatf("bit%0d_of_%02h", b, d), obs_tx, exp_bits[b]);
      if (b == stall_bit) begin
        tick_en = 1'b0;
        held    = obs_tx;
        changes = 0;
        repeat (1000) begin
          @(negedge clk);
          if (obs_tx !== held) changes++;
        end
        chk("stall_line_changes", changes, 0);
        chk("stall_line_level", obs_tx, exp_bits[b]);
        tick_en = 1'b1;
      end
    end
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (obs_done) found = 1'b1;
    end
    chk($sformatf("done_seen_%02h", d), found, 1'b1);
    @(posedge clk);
    #1;
    chk($sformatf("frame_len_%02h", d), tick_cnt - t0, 160 + sb);
    if (expect_idle) chk("busy_low_after_done", obs_busy, 1'b0);
    @(negedge clk);
    chk("done_one_clk", obs_done, 1'b0);
  endtask

  initial begin
    int t0;
    int t1;
    int cnt0;
    logic [7:0] loop_bytes [4];
    loop_bytes = '{8'h00, 8'hFF, 8'h5A, 8'h80};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_tx", tx_a, 1'b1);
    chk("reset_ready", ready_a, 1'b1);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_done", done_a, 1'b0);
    chk("reset_tx_b", tx_b, 1'b1);
    repeat (5) @(negedge clk);

    // Single frame 0xA5, one stop bit.
    cnt0 = done_cnt_a;
    start_frame(1'b0, 8'hA5, t0);
    check_bits(8'hA5, 16, t0, -1, 1'b1);
    chk("single_done_pulse", done_cnt_a, cnt0 + 1);

    // 0x01 on the two-stop-bit instance: parity 1, 192 ticks.
    start_frame(1'b1, 8'h01, t0);
    check_bits(8'h01, 32, t0, -1, 1'b1);
    sel = 1'b0;

    // Receiver-style mid-bit decoding of a few corner bytes.
    foreach (loop_bytes[i]) begin
      start_frame(1'b0, loop_bytes[i], t0);
      check_bits(loop_bytes[i], 16, t0, -1, 1'b1);
    end

    // Back-to-back: 0xC3 queued behind 0x3C, 0x99 offered while full must be dropped.
    cnt0 = done_cnt_a;
    start_frame(1'b0, 8'h3C, t0);
    wait_tick(t0 + 3);
    din_a = 8'hC3; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    chk("ready_drop", ready_a, 1'b0);
    @(negedge clk);
    din_a = 8'h99; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    chk("ready_still_low", ready_a, 1'b0);
    @(negedge clk);
    check_bits(8'h3C, 16, t0, -1, 1'b0);
    t1 = t0 + 176;
    chk("b2b_start_bit", tx_a, 1'b0);
    chk("b2b_ready_back", ready_a, 1'b1);
    chk("b2b_busy", busy_a, 1'b1);
    check_bits(8'hC3, 16, t1, -1, 1'b1);
    wait_tick(tick_cnt + 40);
    chk("b2b_no_third_tx", tx_a, 1'b1);
    chk("b2b_no_third_busy", busy_a, 1'b0);
    chk("b2b_done_count", done_cnt_a, cnt0 + 2);

    // Reset during data bit 3 of 0xF0 (line low there).
    start_frame(1'b0, 8'hF0, t0);
    wait_tick(t0 + 16 * 4 + 4);
    chk("pre_reset_bit3", tx_a, 1'b0);
    cnt0 = done_cnt_a;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_tx", tx_a, 1'b1);
    chk("midreset_busy", busy_a, 1'b0);
    chk("midreset_ready", ready_a, 1'b1);
    chk("midreset_done", done_a, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_no_done", done_cnt_a, cnt0);
    start_frame(1'b0, 8'h12, t0);
    check_bits(8'h12, 16, t0, -1, 1'b1);

    // Stall s_tick for 1000 clocks in the middle of the parity bit.
    start_frame(1'b0, 8'h07, t0);
    check_bits(8'h07, 16, t0, 9, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
